regfile_wb_scheduler: RTL and testbench

//  Shares the single RegisterFile write port between two writeback sources (ALU, MEM) using round-robin valid/ready arbitration.

---
 rtl/regfile_ctrl_pkg.sv | 23 ++
 rtl/wb_rr_arbiter.sv | 56 +++++
 rtl/regfile_wb_scheduler.sv | 139 +++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_ctrl_pkg
// Shared constants and types for the RegisterFile writeback scheduler:
//   DATA_W / ADDR_W / CNT_W - default datapath, register index and
//                             pending-counter widths
//   NUM_REGS / ZERO_REG     - register count and the hard-wired zero register
//   wb_src_e                - encoding of the two writeback sources
// -----------------------------------------------------------------------------
package regfile_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int CNT_W    = 2;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// Two-way round-robin arbiter for the ALU and MEM writeback sources.
// Ports:
//   clk         - clock, state on posedge
//   reset_i     - synchronous active-high reset (pointer -> MEM, grants 0)
//   alu_valid_i - ALU requests the write port
//   mem_valid_i - MEM requests the write port
//   grant_alu_o - one-hot grant to ALU (combinational)
//   grant_mem_o - one-hot grant to MEM (combinational)
// -----------------------------------------------------------------------------
module wb_rr_arbiter
  import regfile_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_i,
  input  logic alu_valid_i,
  input  logic mem_valid_i,
  output logic grant_alu_o,
  output logic grant_mem_o
);

  wb_src_e rr_q;
  logic    both_valid;

  assign both_valid = alu_valid_i && mem_valid_i;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    grant_alu_o = 1'b0;
    grant_mem_o = 1'b0;
    if (!reset_i) begin
      if (both_valid) begin
        grant_mem_o = (rr_q == SRC_MEM);
        grant_alu_o = (rr_q == SRC_ALU);
      end else begin
        grant_mem_o = mem_valid_i;
        grant_alu_o = alu_valid_i;
      end
    end
  end

  // The pointer only moves after real contention; a lone requester never
  // steals the other source's turn.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      rr_q <= SRC_MEM;
    end else if (both_valid) begin
      rr_q <= (rr_q == SRC_MEM) ? SRC_ALU : SRC_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
// Shares the single RegisterFile write port between the ALU and MEM writeback
// sources, drives the write port from a registered stage, and keeps a
// per-register pending-write scoreboard for decode hazard detection.
// Ports:
//   clk, reset                - clock; synchronous active-high reset
//   alu_valid/reg/data, alu_ready - ALU writeback handshake
//   mem_valid/reg/data, mem_ready - MEM (load) writeback handshake
//   issue_valid/reg, issue_ready  - decode announces a future write
//   read_reg1..3, hazard1..3      - decode source registers / RAW hazards
//   EnableWrite, write_reg, write_data - registered RegisterFile write port
//   sb_error                  - sticky: writeback with zero pending count
// -----------------------------------------------------------------------------
module regfile_wb_scheduler #(
  parameter int DATA_W = regfile_ctrl_pkg::DATA_W,
  parameter int ADDR_W = regfile_ctrl_pkg::ADDR_W,
  parameter int CNT_W  = regfile_ctrl_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] read_reg3,
  output logic              hazard1,
  output logic              hazard2,
  output logic              hazard3,
  output logic              EnableWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              sb_error
);

  import regfile_ctrl_pkg::*;

  localparam int                NREGS   = 1 << ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [ADDR_W-1:0] REG0    = ADDR_W'(ZERO_REG);

  // ---------------------------------------------------------------- arbitration
  logic grant_alu, grant_mem;

  wb_rr_arbiter u_arb (
    .clk         (clk),
    .reset_i     (reset),
    .alu_valid_i (alu_valid),
    .mem_valid_i (mem_valid),
    .grant_alu_o (grant_alu),
    .grant_mem_o (grant_mem)
  );

  assign alu_ready = grant_alu;
  assign mem_ready = grant_mem;

  // Grants are only ever raised for a valid source, so a grant is a transfer.
  logic              xfer;
  logic [ADDR_W-1:0] xfer_reg;
  logic [DATA_W-1:0] xfer_data;

  assign xfer      = grant_alu || grant_mem;
  assign xfer_reg  = grant_mem ? mem_reg  : alu_reg;
  assign xfer_data = grant_mem ? mem_data : alu_data;

  // ----------------------------------------------------------------- scoreboard
  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];
  logic             sb_error_q, sb_error_d;
  logic             do_inc, do_dec;

  assign issue_ready = !reset && ((issue_reg == REG0) || (cnt_q[issue_reg] != CNT_MAX));

  // Writes to register 0 are accepted but never reach the RegisterFile and
  // never touch the scoreboard.
  assign do_inc = issue_valid && issue_ready && (issue_reg != REG0);
  assign do_dec = xfer && (xfer_reg != REG0);

  always_comb begin
    sb_error_d = sb_error_q;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      // An issue and a retire of the same register on one edge cancel out.
      if (do_inc && (issue_reg == ADDR_W'(r)) && !(do_dec && (xfer_reg == ADDR_W'(r)))) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (do_dec && (xfer_reg == ADDR_W'(r)) && !(do_inc && (issue_reg == ADDR_W'(r)))) begin
        if (cnt_q[r] == '0) begin
          sb_error_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] - 1'b1;
        end
      end
    end
  end

  assign hazard1 = !reset && (read_reg1 != REG0) && (cnt_q[read_reg1] != '0);
  assign hazard2 = !reset && (read_reg2 != REG0) && (cnt_q[read_reg2] != '0);
  assign hazard3 = !reset && (read_reg3 != REG0) && (cnt_q[read_reg3] != '0);

  // --------------------------------------------------- state and output stage
  logic              write_en_q;
  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;

  // NOTE: the counter array is reset like any other register: hazard outputs
  // read it directly, so stale counts after reset would stall decode forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      sb_error_q   <= 1'b0;
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      sb_error_q <= sb_error_d;
      write_en_q <= do_dec;
      if (do_dec) begin
        write_reg_q  <= xfer_reg;
        write_data_q <= xfer_data;
      end
    end
  end

  assign EnableWrite = write_en_q;
  assign write_reg   = write_reg_q;
  assign write_data  = write_data_q;
  assign sb_error    = sb_error_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid;
  logic [4:0]  alu_reg, mem_reg, issue_reg;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, issue_ready;
  logic [4:0]  read_reg1, read_reg2, read_reg3;
  logic        hazard1, hazard2, hazard3;
  logic        EnableWrite, sb_error;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  int passed = 0;
  int total  = 0;

  // reference model state
  int cnt_m [32];
  bit rr_mem_m;
  bit err_m;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
    .read_reg1(read_reg1), .read_reg2(read_reg2), .read_reg3(read_reg3),
    .hazard1(hazard1), .hazard2(hazard2), .hazard3(hazard3),
    .EnableWrite(EnableWrite), .write_reg(write_reg), .write_data(write_data),
    .sb_error(sb_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_reg = '0; alu_data = '0;
    mem_valid = 0; mem_reg = '0; mem_data = '0;
    issue_valid = 0; issue_reg = '0;
    read_reg1 = '0; read_reg2 = '0; read_reg3 = '0;
  endtask

  task automatic apply_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    alu_valid = 1; alu_reg = 5'd3; alu_data = 32'h11;
    mem_valid = 1; mem_reg = 5'd4; mem_data = 32'h22;
    issue_valid = 1; issue_reg = 5'd3;
    read_reg1 = 5'd3; read_reg2 = 5'd4; read_reg3 = 5'd3;
    tick(); tick(); #1;
    total++; if ({alu_ready, mem_ready} !== 2'b00) $display("FAIL reset_ready got %b exp 00", {alu_ready, mem_ready}); else passed++;
    total++; if (issue_ready !== 1'b0) $display("FAIL reset_issue_ready got %b exp 0", issue_ready); else passed++;
    total++; if ({hazard1, hazard2, hazard3} !== 3'b000) $display("FAIL reset_hazards got %b exp 000", {hazard1, hazard2, hazard3}); else passed++;
    total++; if ({EnableWrite, write_reg, write_data, sb_error} !== 39'd0)
      $display("FAIL reset_outputs got en=%b reg=%0d data=%h err=%b exp all 0", EnableWrite, write_reg, write_data, sb_error); else passed++;
    idle_inputs();
    issue_reg = 5'd3; read_reg1 = 5'd3; read_reg2 = 5'd4;
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (EnableWrite !== 1'b0) $display("FAIL idle_en cycle %0d got %b exp 0", i, EnableWrite); else passed++;
      total++; if ({hazard1, hazard2, hazard3, alu_ready, mem_ready} !== 5'b0)
        $display("FAIL idle_haz_ready cycle %0d got %b exp 00000", i, {hazard1, hazard2, hazard3, alu_ready, mem_ready}); else passed++;
      total++; if (issue_ready !== 1'b1) $display("FAIL idle_issue_ready cycle %0d got %b exp 1", i, issue_ready); else passed++;
    end
  endtask

  task automatic test_single_alu();
    apply_reset();
    issue_valid = 1; issue_reg = 5'd9;
    tick();
    issue_valid = 0; read_reg1 = 5'd9;
    #1;
    total++; if (hazard1 !== 1'b1) $display("FAIL alu_pre_hazard got %b exp 1", hazard1); else passed++;
    alu_valid = 1; alu_reg = 5'd9; alu_data = 32'h4;
    #1;
    total++; if ({alu_ready, mem_ready} !== 2'b10) $display("FAIL alu_ready got %b exp 10", {alu_ready, mem_ready}); else passed++;
    tick();
    alu_valid = 0;
    #1;
    total++; if ({EnableWrite, write_reg, write_data} !== {1'b1, 5'd9, 32'h4})
      $display("FAIL alu_write got en=%b reg=%0d data=%h exp 1/9/4", EnableWrite, write_reg, write_data); else passed++;
    total++; if (hazard1 !== 1'b0) $display("FAIL alu_post_hazard got %b exp 0", hazard1); else passed++;
    tick();
    total++; if ({EnableWrite, sb_error} !== 2'b00) $display("FAIL alu_idle got en=%b err=%b exp 0/0", EnableWrite, sb_error); else passed++;
  endtask

  task automatic test_alternating();
    bit exp_mem;
    apply_reset();
    alu_valid = 1; alu_reg = 5'd5; alu_data = 32'hA1A1_0005;
    mem_valid = 1; mem_reg = 5'd6; mem_data = 32'hBEEF_0006;
    for (int k = 0; k < 6; k++) begin
      exp_mem = (k % 2 == 0);
      #1;
      total++; if ({alu_ready, mem_ready} !== {!exp_mem, exp_mem})
        $display("FAIL alt_grant cycle %0d got %b exp %b", k, {alu_ready, mem_ready}, {!exp_mem, exp_mem}); else passed++;
      tick();
      total++; if ({EnableWrite, write_reg, write_data} !== (exp_mem ? {1'b1, 5'd6, 32'hBEEF_0006} : {1'b1, 5'd5, 32'hA1A1_0005}))
        $display("FAIL alt_write cycle %0d got en=%b reg=%0d data=%h", k, EnableWrite, write_reg, write_data); else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_hazard();
    apply_reset();
    issue_valid = 1; issue_reg = 5'd19;
    tick();
    issue_valid = 0; read_reg1 = 5'd19; read_reg3 = 5'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({hazard1, hazard3} !== 2'b10) $display("FAIL haz_pending cycle %0d got %b exp 10", i, {hazard1, hazard3}); else passed++;
      tick();
    end
    mem_valid = 1; mem_reg = 5'd19; mem_data = 32'h1919;
    #1;
    total++; if ({mem_ready, hazard1} !== 2'b11) $display("FAIL haz_xfer got ready/haz %b exp 11", {mem_ready, hazard1}); else passed++;
    tick();
    mem_valid = 0;
    #1;
    total++; if (hazard1 !== 1'b0) $display("FAIL haz_clear got %b exp 0", hazard1); else passed++;
    total++; if ({EnableWrite, write_reg} !== {1'b1, 5'd19}) $display("FAIL haz_write got en=%b reg=%0d exp 1/19", EnableWrite, write_reg); else passed++;
  endtask

  task automatic test_saturation();
    apply_reset();
    issue_reg = 5'd20; read_reg2 = 5'd20; issue_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (issue_ready !== 1'b1) $display("FAIL sat_fill %0d got %b exp 1", i, issue_ready); else passed++;
      tick();
    end
    #1;
    total++; if (issue_ready !== 1'b0) $display("FAIL sat_full got %b exp 0", issue_ready); else passed++;
    tick();  // blocked issue must not change the count
    #1;
    total++; if ({issue_ready, hazard2} !== 2'b01) $display("FAIL sat_blocked got %b exp 01", {issue_ready, hazard2}); else passed++;
    issue_valid = 0;
    alu_valid = 1; alu_reg = 5'd20; alu_data = 32'h2020;
    tick();  // count 3 -> 2
    alu_valid = 0;
    #1;
    total++; if (issue_ready !== 1'b1) $display("FAIL sat_after_wb got %b exp 1", issue_ready); else passed++;
    issue_valid = 1; alu_valid = 1;
    #1;
    total++; if ({issue_ready, alu_ready} !== 2'b11) $display("FAIL sat_same_cycle got %b exp 11", {issue_ready, alu_ready}); else passed++;
    tick();  // issue + writeback of r20 cancel: count stays 2
    alu_valid = 0;
    tick();  // plain issue: 2 -> 3
    issue_valid = 0;
    #1;
    total++; if (issue_ready !== 1'b0) $display("FAIL sat_refill got %b exp 0", issue_ready); else passed++;
    mem_valid = 1; mem_reg = 5'd20; mem_data = 32'h5A5A;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      total++; if (hazard2 !== (i < 2)) $display("FAIL sat_drain %0d got %b exp %b", i, hazard2, (i < 2)); else passed++;
    end
    mem_valid = 0;
    tick();
    total++; if (sb_error !== 1'b0) $display("FAIL sat_err got %b exp 0", sb_error); else passed++;
  endtask

  task automatic test_r0_and_error();
    apply_reset();
    issue_valid = 1; issue_reg = 5'd0; read_reg1 = 5'd0;
    #1;
    total++; if ({issue_ready, hazard1} !== 2'b10) $display("FAIL r0_issue got %b exp 10", {issue_ready, hazard1}); else passed++;
    tick();
    issue_valid = 0;
    alu_valid = 1; alu_reg = 5'd0; alu_data = 32'hDEAD_BEEF;
    #1;
    total++; if (alu_ready !== 1'b1) $display("FAIL r0_ready got %b exp 1", alu_ready); else passed++;
    tick();
    alu_valid = 0;
    total++; if ({EnableWrite, sb_error} !== 2'b00) $display("FAIL r0_write got en=%b err=%b exp 0/0", EnableWrite, sb_error); else passed++;
    mem_valid = 1; mem_reg = 5'd7; mem_data = 32'h7777;
    tick();
    mem_valid = 0;
    total++; if ({EnableWrite, write_reg, sb_error} !== {1'b1, 5'd7, 1'b1})
      $display("FAIL err_set got en=%b reg=%0d err=%b exp 1/7/1", EnableWrite, write_reg, sb_error); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (sb_error !== 1'b1) $display("FAIL err_sticky %0d got %b exp 1", i, sb_error); else passed++;
    end
    reset = 1;
    tick();
    reset = 0;
    total++; if (sb_error !== 1'b0) $display("FAIL err_reset got %b exp 0", sb_error); else passed++;
  endtask

  function automatic logic [4:0] pick_wb_reg();
    int live[$];
    for (int r = 1; r < 8; r++) if (cnt_m[r] != 0) live.push_back(r);
    if (live.size() != 0 && $urandom_range(0, 3) != 0) return 5'(live[$urandom_range(0, live.size() - 1)]);
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    bit          alu_hold, mem_hold, g_alu, g_mem, exp_ir, inc, dec;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [2:0]  exp_haz;
    apply_reset();
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    rr_mem_m = 1; err_m = 0; alu_hold = 0; mem_hold = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      // an ungranted request is held unchanged
      if (!alu_hold) begin alu_valid = 1'($urandom_range(0, 1)); alu_reg = pick_wb_reg(); alu_data = $urandom; end
      if (!mem_hold) begin mem_valid = 1'($urandom_range(0, 1)); mem_reg = pick_wb_reg(); mem_data = $urandom; end
      issue_valid = ($urandom_range(0, 2) != 0);
      issue_reg = 5'($urandom_range(0, 7));
      read_reg1 = 5'($urandom_range(0, 7));
      read_reg2 = 5'($urandom_range(0, 7));
      read_reg3 = 5'($urandom_range(0, 7));
      #1;
      g_mem = mem_valid && (!alu_valid || rr_mem_m);
      g_alu = alu_valid && !g_mem;
      exp_ir = (issue_reg == 0) || (cnt_m[issue_reg] < 3);
      exp_haz = {(read_reg1 != 0) && (cnt_m[read_reg1] != 0),
                 (read_reg2 != 0) && (cnt_m[read_reg2] != 0),
                 (read_reg3 != 0) && (cnt_m[read_reg3] != 0)};
      total++; if ({alu_ready, mem_ready} !== {g_alu, g_mem}) $display("FAIL rnd_grant cyc %0d got %b exp %b", cyc, {alu_ready, mem_ready}, {g_alu, g_mem}); else passed++;
      total++; if (issue_ready !== exp_ir) $display("FAIL rnd_issue_ready cyc %0d got %b exp %b", cyc, issue_ready, exp_ir); else passed++;
      total++; if ({hazard1, hazard2, hazard3} !== exp_haz) $display("FAIL rnd_hazard cyc %0d got %b exp %b", cyc, {hazard1, hazard2, hazard3}, exp_haz); else passed++;
      if (alu_valid && mem_valid) rr_mem_m = !rr_mem_m;
      wb_reg  = g_mem ? mem_reg : alu_reg;
      wb_data = g_mem ? mem_data : alu_data;
      inc = issue_valid && exp_ir && (issue_reg != 0);
      dec = (g_alu || g_mem) && (wb_reg != 0);
      if (!(inc && dec && issue_reg == wb_reg)) begin
        if (inc) cnt_m[issue_reg]++;
        if (dec) begin
          if (cnt_m[wb_reg] == 0) err_m = 1;
          else cnt_m[wb_reg]--;
        end
      end
      alu_hold = alu_valid && !g_alu;
      mem_hold = mem_valid && !g_mem;
      tick();
      total++; if (EnableWrite !== dec) $display("FAIL rnd_en cyc %0d got %b exp %b", cyc, EnableWrite, dec); else passed++;
      if (dec) begin
        total++; if ({write_reg, write_data} !== {wb_reg, wb_data})
          $display("FAIL rnd_write cyc %0d got %0d/%h exp %0d/%h", cyc, write_reg, write_data, wb_reg, wb_data); else passed++;
      end
      total++; if (sb_error !== err_m) $display("FAIL rnd_err cyc %0d got %b exp %b", cyc, sb_error, err_m); else passed++;
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_single_alu();
    test_alternating();
    test_hazard();
    test_saturation();
    test_r0_and_error();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
